// File: rtl/radio_uplink_tx.sv
// radio_uplink_tx
// ---------------
// Serial uplink transmitter for the 4-wire radio interface (RPULSE, RD1, RD0,
// RCHECK). A 14-bit command word is accepted over a valid/ready handshake and
// sent as one sync pulse followed by 7 data pulses of 2 bits each, MSB pair
// first. Each data pulse carries its own parity on RCHECK. An optional corrupt
// request inverts the parity of exactly one data pulse so the receiver's
// validity logic can be exercised.
//
// Every pulse is SETUP_CYC cycles with RPULSE low, then HIGH_CYC cycles with
// RPULSE high, then LOW_CYC cycles with RPULSE low. RD1/RD0/RCHECK change only
// on the first SETUP cycle and are held through HIGH and LOW.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   tx_word     word to send; bits [13:12] go out first
//   tx_corrupt  sampled with tx_word; requests one parity error in the frame
//   tx_valid    tx_word/tx_corrupt valid
//   tx_ready    high only in IDLE; transfer on tx_valid && tx_ready
//   busy        high whenever a frame is in progress
//   frame_done  one-cycle pulse in the first IDLE cycle after a frame
//   RPULSE      strobe; receiver samples RD1/RD0/RCHECK on its rising edge
//   RD1, RD0    upper / lower bit of the current pair (1/1 during sync)
//   RCHECK      RD1 ^ RD0, inverted on the corrupted pulse; 1 during sync

module radio_uplink_tx #(
    parameter int SETUP_CYC = 2,
    parameter int HIGH_CYC  = 4,
    parameter int LOW_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] tx_word,
    input  logic        tx_corrupt,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        RPULSE,
    output logic        RD1,
    output logic        RD0,
    output logic        RCHECK
);

    localparam int MAX_CYC = (SETUP_CYC > HIGH_CYC)
                           ? ((SETUP_CYC > LOW_CYC) ? SETUP_CYC : LOW_CYC)
                           : ((HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(LOW_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LOW   = 2'd3;

    localparam logic [2:0] LAST_PULSE = 3'd7;

    logic [1:0]       state;
    logic [CNT_W-1:0] phase_cnt;
    logic [2:0]       pulse_idx;
    logic [13:0]      word_q;
    // Index of the data pulse whose check bit is inverted; 0 means none,
    // which can never match a data pulse (1..7).
    logic [2:0]       corrupt_idx;

    // Pair carried by data pulse k (1..7): word[15-2k:14-2k].
    function automatic logic [1:0] pair_at(input logic [13:0] w, input logic [2:0] k);
        logic [4:0] sh;
        sh = 5'd14 - {1'b0, k, 1'b0};
        return 2'(w >> sh);
    endfunction

    // The corrupted pulse is the first data pulse whose pair is not 11:
    // inverting the check of an 11 pair would present 1/1/1, i.e. a sync.
    // An all-ones word therefore goes out clean even when corruption is asked.
    function automatic logic [2:0] find_corrupt_idx(input logic [13:0] w, input logic req);
        logic [2:0] idx;
        idx = 3'd0;
        if (req) begin
            // Scan downwards so the lowest qualifying pulse wins.
            for (int k = 7; k >= 1; k--) begin
                if (pair_at(w, 3'(k)) != 2'b11) begin
                    idx = 3'(k);
                end
            end
        end
        return idx;
    endfunction

    // {RD1, RD0, RCHECK} presented during pulse k.
    function automatic logic [2:0] line_bits(input logic [13:0] w, input logic [2:0] k,
                                             input logic [2:0] cidx);
        logic [1:0] pair;
        logic       chk;
        if (k == 3'd0) begin
            return 3'b111;
        end
        pair = pair_at(w, k);
        chk  = pair[1] ^ pair[0] ^ (k == cidx);
        return {pair, chk};
    endfunction

    assign tx_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase_cnt  <= '0;
            pulse_idx  <= '0;
            frame_done <= 1'b0;
            RPULSE     <= 1'b0;
            RD1        <= 1'b0;
            RD0        <= 1'b0;
            RCHECK     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        word_q             <= tx_word;
                        corrupt_idx        <= find_corrupt_idx(tx_word, tx_corrupt);
                        state              <= ST_SETUP;
                        phase_cnt          <= '0;
                        pulse_idx          <= 3'd0;
                        {RD1, RD0, RCHECK} <= 3'b111;
                    end
                end

                ST_SETUP: begin
                    if (phase_cnt == SETUP_LAST) begin
                        phase_cnt <= '0;
                        state     <= ST_HIGH;
                        RPULSE    <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                ST_HIGH: begin
                    if (phase_cnt == HIGH_LAST) begin
                        phase_cnt <= '0;
                        state     <= ST_LOW;
                        RPULSE    <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                ST_LOW: begin
                    if (phase_cnt == LOW_LAST) begin
                        phase_cnt <= '0;
                        if (pulse_idx == LAST_PULSE) begin
                            // Lines drop together with the return to IDLE so
                            // frame_done and tx_ready coincide.
                            state              <= ST_IDLE;
                            frame_done         <= 1'b1;
                            {RD1, RD0, RCHECK} <= 3'b000;
                        end else begin
                            state              <= ST_SETUP;
                            pulse_idx          <= pulse_idx + 3'd1;
                            {RD1, RD0, RCHECK} <= line_bits(word_q, pulse_idx + 3'd1,
                                                            corrupt_idx);
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_radio_uplink_tx.sv
// Testbench for radio_uplink_tx: default-parameter instance plus a
// SETUP=1/HIGH=2/LOW=2 instance, per-cycle trace comparison against a
// behavioural frame model and a reference receiver that reassembles words.

module tb_radio_uplink_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] tx_word;
    logic        tx_corrupt;
    logic        valid_a, valid_b;

    logic a_ready, a_busy, a_done, a_rp, a_rd1, a_rd0, a_chk;
    logic b_ready, b_busy, b_done, b_rp, b_rd1, b_rd0, b_chk;

    always #5 clk = ~clk;

    radio_uplink_tx dut_a (
        .clk(clk), .rst(rst), .tx_word(tx_word), .tx_corrupt(tx_corrupt),
        .tx_valid(valid_a), .tx_ready(a_ready), .busy(a_busy), .frame_done(a_done),
        .RPULSE(a_rp), .RD1(a_rd1), .RD0(a_rd0), .RCHECK(a_chk)
    );

    radio_uplink_tx #(.SETUP_CYC(1), .HIGH_CYC(2), .LOW_CYC(2)) dut_b (
        .clk(clk), .rst(rst), .tx_word(tx_word), .tx_corrupt(tx_corrupt),
        .tx_valid(valid_b), .tx_ready(b_ready), .busy(b_busy), .frame_done(b_done),
        .RPULSE(b_rp), .RD1(b_rd1), .RD0(b_rd0), .RCHECK(b_chk)
    );

    int checks   = 0;
    int failures = 0;

    // Receiver capture of the last frame (index 0 = sync).
    logic [1:0] rx_pair [0:7];
    logic       rx_chk  [0:7];
    int         rx_edge [0:7];

    typedef struct {
        logic [13:0] w;
        logic        cor;
        logic [13:0] exp_w;
        bit          exp_ok;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // {tx_ready, busy, frame_done, RPULSE, RD1, RD0, RCHECK}
    function automatic logic [6:0] obs(input int sel);
        if (sel == 0) return {a_ready, a_busy, a_done, a_rp, a_rd1, a_rd0, a_chk};
        return {b_ready, b_busy, b_done, b_rp, b_rd1, b_rd0, b_chk};
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel == 0) valid_a = v;
        else          valid_b = v;
    endtask

    function automatic int first_non11(input logic [13:0] w);
        int wi;
        wi = int'(w);
        for (int k = 1; k <= 7; k++)
            if (((wi >> (14 - 2 * k)) & 3) != 3) return k;
        return 0;
    endfunction

    // Expected outputs in cycle c after the handshake (c = 1 .. 8P+1).
    function automatic logic [6:0] exp_obs(input int s, input int h, input int l,
                                           input logic [13:0] w, input logic cor, input int c);
        int p, k, ph, pr, wi;
        logic rp, chk;
        logic [2:0] lines;
        p = s + h + l;
        if (c == 8 * p + 1) return 7'b1010000;
        k  = (c - 1) / p;
        ph = (c - 1) % p;
        rp = (ph >= s) && (ph < s + h);
        if (k == 0) begin
            lines = 3'b111;
        end else begin
            wi  = int'(w);
            pr  = (wi >> (14 - 2 * k)) & 3;
            chk = pr[1] ^ pr[0];
            if (cor && k == first_non11(w)) chk = ~chk;
            lines = {pr[1:0], chk};
        end
        return {1'b0, 1'b1, 1'b0, rp, lines};
    endfunction

    // Handshake at the next posedge (caller is at a negedge), then check every
    // cycle of the frame up to and including the frame_done cycle. Returns at
    // the negedge of the frame_done cycle. keep=1 leaves tx_valid high at the
    // end so the caller can chain a frame into the frame_done cycle.
    task automatic run_frame(input int sel, input logic [13:0] w, input logic cor,
                             input bit keep, output logic [13:0] rx_w, output bit rx_ok);
        int s, h, l, p, n;
        logic [6:0] o, e;
        logic prev_rp;
        logic [2:0] prev_lines;
        bit synced;
        if (sel == 0) begin s = 2; h = 4; l = 4; end
        else          begin s = 1; h = 2; l = 2; end
        p = s + h + l;
        check($sformatf("ready_before_s%0d", sel), {31'b0, obs(sel)[6]}, 1);
        prev_lines = obs(sel)[2:0];
        tx_word    = w;
        tx_corrupt = cor;
        set_valid(sel, 1'b1);
        @(posedge clk);
        prev_rp = 1'b0;
        synced  = 1'b0;
        n       = 0;
        rx_w    = '0;
        rx_ok   = 1'b0;
        for (int c = 1; c <= 8 * p + 1; c++) begin
            @(negedge clk);
            if (c < 8 * p) begin
                // Activity on the request side while busy must be ignored.
                set_valid(sel, 1'($urandom_range(0, 1)));
                tx_word    = 14'($urandom);
                tx_corrupt = 1'($urandom);
            end else if (c == 8 * p) begin
                set_valid(sel, keep);
            end
            o = obs(sel);
            e = exp_obs(s, h, l, w, cor, c);
            check($sformatf("trace_s%0d_w%04h_c%0d", sel, w, c), o, e);
            if (c <= 8 * p && (c - 1) / p > 0 && o[3])
                check($sformatf("no_sync_mimic_c%0d", c), {31'b0, o[2:0] == 3'b111}, 0);
            if (c <= 8 * p && o[2:0] !== prev_lines)
                check($sformatf("line_change_phase_c%0d", c), (c - 1) % p, 0);
            prev_lines = o[2:0];
            if (o[3] && !prev_rp) begin
                if (o[2:0] == 3'b111) begin
                    synced = 1'b1; n = 0; rx_ok = 1'b1; rx_w = '0; rx_edge[0] = c;
                end else if (synced && n < 7) begin
                    n++;
                    rx_pair[n] = o[2:1];
                    rx_chk[n]  = o[0];
                    rx_edge[n] = c;
                    rx_w = {rx_w[11:0], o[2:1]};
                    if (o[0] !== (o[2] ^ o[1])) rx_ok = 1'b0;
                end
            end
            prev_rp = o[3];
        end
        rx_ok = rx_ok && synced && (n == 7);
    endtask

    vec_t        tbl [6];
    logic [1:0]  exp_pairs [1:7];
    logic        exp_chks  [1:7];
    logic [13:0] rx_w, w;
    bit          rx_ok;
    logic        cor;

    initial begin
        tbl[0] = '{14'h1234, 1'b0, 14'h1234, 1'b1};
        tbl[1] = '{14'h1234, 1'b1, 14'h1234, 1'b0};
        tbl[2] = '{14'h3FFF, 1'b1, 14'h3FFF, 1'b1};
        tbl[3] = '{14'h0000, 1'b1, 14'h0000, 1'b0};
        tbl[4] = '{14'h2AAA, 1'b0, 14'h2AAA, 1'b1};
        tbl[5] = '{14'h3FFC, 1'b1, 14'h3FFC, 1'b0};
        exp_pairs = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00};
        exp_chks  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; tx_word = '0; tx_corrupt = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state_a", obs(0), 7'b1000000);
        check("reset_state_b", obs(1), 7'b1000000);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven frames on the default instance.
        for (int i = 0; i < 6; i++) begin
            run_frame(0, tbl[i].w, tbl[i].cor, 1'b0, rx_w, rx_ok);
            check($sformatf("rx_word_%0d", i), rx_w, tbl[i].exp_w);
            check($sformatf("rx_valid_%0d", i), {31'b0, rx_ok}, {31'b0, tbl[i].exp_ok});
            if (i == 0) begin
                check("sync_edge", rx_edge[0], 3);
                for (int k = 1; k <= 7; k++) begin
                    check($sformatf("pair_%0d", k), rx_pair[k], exp_pairs[k]);
                    check($sformatf("chk_%0d", k), rx_chk[k], exp_chks[k]);
                    check($sformatf("edge_%0d", k), rx_edge[k], 3 + 10 * k);
                end
            end
            if (i == 1) begin
                for (int k = 1; k <= 7; k++)
                    check($sformatf("corrupt_chk_%0d", k), rx_chk[k],
                          (k == 1) ? 1'b0 : exp_chks[k]);
            end
            if (i == 2) begin
                for (int k = 1; k <= 7; k++) begin
                    check($sformatf("allones_pair_%0d", k), rx_pair[k], 2'b11);
                    check($sformatf("allones_chk_%0d", k), rx_chk[k], 1'b0);
                end
            end
        end

        // Back-to-back with tx_valid held across the frame_done cycle.
        run_frame(0, 14'h0001, 1'b0, 1'b1, rx_w, rx_ok);
        check("b2b_first_word", rx_w, 14'h0001);
        check("b2b_first_valid", {31'b0, rx_ok}, 1);
        run_frame(0, 14'h2AAA, 1'b0, 1'b0, rx_w, rx_ok);
        check("b2b_second_word", rx_w, 14'h2AAA);
        check("b2b_second_valid", {31'b0, rx_ok}, 1);
        check("b2b_sync_edge_abs", 81 + rx_edge[0], 84);

        // Randomized frames against the model.
        for (int i = 0; i < 16; i++) begin
            w   = 14'($urandom);
            if (i % 5 == 0) w = 14'h3FFF;
            cor = 1'($urandom);
            run_frame(0, w, cor, 1'($urandom), rx_w, rx_ok);
            check($sformatf("rand_word_%0d", i), rx_w, w);
            check($sformatf("rand_valid_%0d", i), {31'b0, rx_ok},
                  {31'b0, !(cor && w != 14'h3FFF)});
        end
        set_valid(0, 1'b0);
        repeat (2) @(negedge clk);

        // Minimum-timing instance.
        run_frame(1, 14'h1234, 1'b0, 1'b0, rx_w, rx_ok);
        check("sweep_word", rx_w, 14'h1234);
        check("sweep_valid", {31'b0, rx_ok}, 1);
        check("sweep_sync_edge", rx_edge[0], 2);
        run_frame(1, 14'h3FFF, 1'b1, 1'b0, rx_w, rx_ok);
        check("sweep_allones_valid", {31'b0, rx_ok}, 1);
        for (int i = 0; i < 4; i++) begin
            w   = 14'($urandom);
            cor = 1'($urandom);
            run_frame(1, w, cor, 1'b0, rx_w, rx_ok);
            check($sformatf("sweep_rand_word_%0d", i), rx_w, w);
            check($sformatf("sweep_rand_valid_%0d", i), {31'b0, rx_ok},
                  {31'b0, !(cor && w != 14'h3FFF)});
        end
        repeat (2) @(negedge clk);

        // Reset in the middle of a frame.
        tx_word = 14'h1555; tx_corrupt = 1'b0; valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        check("midframe_busy", {31'b0, a_busy}, 1);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midreset_cycle_%0d", i), obs(0), 7'b1000000);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle_%0d", i), obs(0), 7'b1000000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/radio_uplink_tx.md
Name: radio_uplink_tx

Overview:
Serial uplink transmitter that drives the 4-wire radio interface (RPULSE, RD1, RD0, RCHECK) the CPLD radio receiver decodes. It takes a 14-bit command word over a valid/ready handshake and emits one sync pulse followed by 7 data pulses of 2 bits each, MSB pair first, with per-pulse parity. It sits in the ground-station / test-harness CPLD and connects directly to the flight-side receiver lines. A corrupt-frame option exists for exercising the receiver's validity logic.

Parameters:
SETUP_CYC, 2, cycles data/check lines are stable with RPULSE low before each rising edge (min 1)
HIGH_CYC, 4, cycles RPULSE held high per pulse (min 2; sync detection needs at least 2 receiver clocks high)
LOW_CYC, 4, cycles RPULSE low after each pulse, with data/check held (min 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tx_word  in  14  word to send; bits [13:12] go out first
tx_corrupt  in  1  sampled with tx_word; requests a parity error in the frame
tx_valid  in  1  tx_word/tx_corrupt valid
tx_ready  out  1  high only in IDLE; a transfer happens when tx_valid && tx_ready
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse when a frame completes
RPULSE  out  1  strobe; the receiver samples RD1/RD0/RCHECK on its rising edge
RD1  out  1  upper bit of the current pair
RD0  out  1  lower bit of the current pair
RCHECK  out  1  RD1 ^ RD0 (inverted on the corrupted pulse); 1 during sync

Behaviour:
- Reset: state IDLE. RPULSE=RD1=RD0=RCHECK=0, busy=0, frame_done=0, tx_ready=1. All counters cleared.
- Reset mid-frame: lines go to 0 on the next edge and the frame is abandoned. No frame_done is issued. The next frame's sync realigns the receiver.
- Handshake: on a clk edge with tx_valid && tx_ready, latch the word and corrupt bit. From the next cycle: busy=1, tx_ready=0. tx_valid is ignored while busy.
- Pulse structure: a frame is 8 pulses, k=0 for sync and k=1..7 for data. Each pulse has three phases:
  - SETUP: SETUP_CYC cycles, RPULSE=0
  - HIGH: HIGH_CYC cycles, RPULSE=1
  - LOW: LOW_CYC cycles, RPULSE=0
- Line updates: RD1, RD0 and RCHECK change only on the first cycle of SETUP. They are held through HIGH and LOW.
- Sync pulse (k=0): RD1=RD0=RCHECK=1.
- Data pulse k: {RD1,RD0} = word[15-2k:14-2k]. RCHECK = RD1^RD0, unless this is the corrupt pulse, in which case it is inverted.
- Corrupt pulse selection: the first data pulse whose pair != 2'b11.
  - This rule exists because an inverted check on pair 11 would mimic sync.
  - If every pair is 11 (word 14'h3FFF), corruption is suppressed and the frame is sent clean.
- Data pulses never present RD1=RD0=RCHECK=1 while RPULSE is high.
- State machine: IDLE -> SETUP -> HIGH -> LOW, with a phase counter and a pulse index 0..7.
  - LOW with index<7 -> SETUP, index+1.
  - LOW with index=7 -> IDLE.
- Frame end: on entering IDLE, RD1/RD0/RCHECK go to 0, and frame_done=1 for exactly that first IDLE cycle. tx_ready=1 in the same cycle, so a back-to-back frame may be accepted then.
- Timing: with P = SETUP_CYC+HIGH_CYC+LOW_CYC and the handshake edge at cycle 0:
  - pulse k occupies cycles 1+kP .. (k+1)P
  - the RPULSE rising edge falls at cycle 1+kP+SETUP_CYC
  - frame_done occurs at cycle 8P+1
  - defaults: P=10, frame_done at cycle 81
- Counters: the phase counter is wide enough for max(SETUP_CYC, HIGH_CYC, LOW_CYC). The pulse index is 3 bits and saturates logically at 7 (no wrap).

Test Plan:
- Reset: assert rst for 3 cycles mid-frame -> next cycle all four radio lines 0, tx_ready=1, busy=0, no frame_done.
- Single frame, tx_word=14'h1234, corrupt=0, defaults:
  - sync rising edge at cycle 3 with RD1=RD0=RCHECK=1
  - data pairs at edges 13,23,...,73 are 01,00,10,00,11,01,00 with RCHECK 1,0,1,0,0,1,0
  - frame_done at cycle 81
  - a reference receiver model reassembles 14'h1234 with valid=1
- Corrupt frame, tx_word=14'h1234, corrupt=1 -> pulse 1 (pair 01) has RCHECK=0, all others as above; the receiver model flags invalid.
- Corrupt on 14'h3FFF -> all pairs 11 with RCHECK=0, no RCHECK=1 data pulse, receiver model valid; also check no data pulse ever shows all-ones with RPULSE high.
- Back-to-back: hold tx_valid high with words 14'h0001 then 14'h2AAA -> second handshake exactly in the frame_done cycle, second sync edge at cycle 81+3; tx_valid changes while busy are ignored.
- Parameter sweep SETUP_CYC=1, HIGH_CYC=2, LOW_CYC=2 -> P=5, frame_done at cycle 41, line changes only on SETUP first cycles.
